uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, eight data bits LSB first, stop bit, then one
// CLEANUP cycle that pulses done. All outputs come straight from flops.
module uart_tx #(
  parameter int unsigned CLOCK_PER_BIT = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       TX_start,
  input  logic [7:0] TX_byte,
  output logic       TX_data,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    CLEANUP   = 3'd4
  } state_e;

  localparam logic [15:0] CNT_LAST = 16'(CLOCK_PER_BIT - 1);

  state_e      state_q;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [2:0]  bit_idx_q;
  logic [2:0]  bit_idx_d;
  logic [7:0]  hold_q;
  logic        tx_q;
  logic        busy_q;
  logic        done_q;
  logic        bit_end;

  assign cnt_d     = cnt_q + 16'd1;
  assign bit_idx_d = bit_idx_q + 3'd1;
  assign bit_end   = (cnt_q == CNT_LAST);

  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; blocking assignments would make the result order-dependent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      // NOTE: the hold register is reset too, so an aborted frame leaves no
      // stale byte behind.
      hold_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          if (TX_start) begin
            hold_q  <= TX_byte;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START_BIT;
          end
        end

        START_BIT: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= hold_q[0];
            state_q <= DATA_BITS;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        DATA_BITS: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              bit_idx_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= STOP_BIT;
            end else begin
              bit_idx_q <= bit_idx_d;
              tx_q      <= hold_q[bit_idx_d];
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        STOP_BIT: begin
          if (bit_end) begin
            cnt_q   <= '0;
            done_q  <= 1'b1;
            state_q <= CLEANUP;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        CLEANUP: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          bit_idx_q <= '0;
          tx_q      <= 1'b1;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end

  assign TX_data = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: one instance at 20 clocks/bit, one at 2 clocks/bit.
// Cycle n is the clock period following the edge that accepted TX_start (edge 0).
module tb_uart_tx;

  localparam int CPB = 20;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       tx_data;
  logic       busy;
  logic       done;

  logic       start2 = 1'b0;
  logic [7:0] byte2  = 8'h00;
  logic       tx2;
  logic       busy2;
  logic       done2;

  int n_tests    = 0;
  int n_fail     = 0;
  int cyc        = 0;
  int high_run   = 0;
  int last_run   = 0;
  int gap_before = 0;
  int done_seen  = 0;
  int low_seen   = 0;
  int done_gap;
  int done_at[$];

  uart_tx #(.CLOCK_PER_BIT(CPB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .TX_start (tx_start),
    .TX_byte  (tx_byte),
    .TX_data  (tx_data),
    .busy     (busy),
    .done     (done)
  );

  uart_tx #(.CLOCK_PER_BIT(2)) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .TX_start (start2),
    .TX_byte  (byte2),
    .TX_data  (tx2),
    .busy     (busy2),
    .done     (done2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One negedge sample of the 20-clock instance, with line/done bookkeeping.
  task automatic sample(input string tag, input logic etx, input logic ebusy, input logic edone);
    @(negedge clk);
    cyc++;
    if (tx_data === 1'b1) high_run++;
    else begin
      last_run = high_run;
      high_run = 0;
    end
    if (done === 1'b1) done_at.push_back(cyc);
    check({tag, " tx"},   16'(tx_data), 16'(etx));
    check({tag, " busy"}, 16'(busy),    16'(ebusy));
    check({tag, " done"}, 16'(done),    16'(edone));
  endtask

  // mode 0: plain, 1: second start at cycle 50, 2: byte changed at cycle 30,
  // 3: start held high and next byte (0x0F) presented at cycle 1.
  task automatic frame(input logic [7:0] b, input int mode);
    logic etx;
    tx_byte  = b;
    tx_start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 201; c++) begin
      if (c <= 20)       etx = 1'b0;
      else if (c <= 180) etx = b[(c - 21) / CPB];
      else               etx = 1'b1;
      sample($sformatf("f%02h c%0d", b, c), etx, 1'b1, c == 201);
      if (c == 1) gap_before = last_run;
      if (c == 1 && mode != 3) tx_start = 1'b0;
      if (c == 1 && mode == 3) tx_byte = 8'h0F;
      if (mode == 1 && c == 50) begin
        tx_start = 1'b1;
        tx_byte  = 8'hFF;
      end
      if (mode == 1 && c == 51) tx_start = 1'b0;
      if (mode == 2 && c == 30) tx_byte = 8'h00;
    end
  endtask

  initial begin
    // Asynchronous reset: outputs must settle before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("rst tx",    16'(tx_data), 16'd1);
    check("rst busy",  16'(busy),    16'd0);
    check("rst done",  16'(done),    16'd0);
    check("rst tx2",   16'(tx2),     16'd1);
    check("rst busy2", 16'(busy2),   16'd0);
    check("rst done2", 16'(done2),   16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sample("idle0", 1'b1, 1'b0, 1'b0);

    // Basic 0xA5 frame.
    done_at.delete();
    frame(8'hA5, 0);
    sample("a5 idle", 1'b1, 1'b0, 1'b0);
    check("a5 done count", 16'(done_at.size()), 16'd1);

    // Start while busy is ignored and not queued.
    done_at.delete();
    frame(8'hA5, 1);
    for (int i = 0; i < 6; i++) sample($sformatf("ign idle%0d", i), 1'b1, 1'b0, 1'b0);
    check("ign done count", 16'(done_at.size()), 16'd1);

    // Byte change after acceptance does not disturb the frame.
    frame(8'hA5, 2);
    sample("chg idle", 1'b1, 1'b0, 1'b0);

    // Start held high: back-to-back 0x55 then 0x0F.
    done_at.delete();
    frame(8'h55, 3);
    sample("held idle", 1'b1, 1'b0, 1'b0);
    frame(8'h0F, 0);
    check("held line gap", 16'(gap_before), 16'd22);
    sample("held end idle", 1'b1, 1'b0, 1'b0);
    check("held done count", 16'(done_at.size()), 16'd2);
    done_gap = (done_at.size() >= 2) ? (done_at[1] - done_at[0] - 1) : -1;
    check("held done gap", 16'(done_gap), 16'd201);

    // Reset during cycle 100 of a frame aborts it without a done pulse.
    tx_byte  = 8'hA5;
    tx_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_start = 1'b0;
    repeat (98) @(negedge clk);
    @(posedge clk);
    #2;
    check("abort pre tx",   16'(tx_data), 16'd0);
    check("abort pre busy", 16'(busy),    16'd1);
    rst_n = 1'b0;
    #1;
    check("abort tx",   16'(tx_data), 16'd1);
    check("abort busy", 16'(busy),    16'd0);
    check("abort done", 16'(done),    16'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 230; i++) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
      if (tx_data !== 1'b1) low_seen++;
    end
    check("abort no done", 16'(done_seen), 16'd0);
    check("abort line idle", 16'(low_seen), 16'd0);
    frame(8'hA5, 0);
    sample("post rst idle", 1'b1, 1'b0, 1'b0);

    // Minimum bit time: 0x00 at 2 clocks per bit.
    byte2  = 8'h00;
    start2 = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      check($sformatf("cpb2 c%0d tx", c),   16'(tx2),   16'(c >= 19));
      check($sformatf("cpb2 c%0d busy", c), 16'(busy2), 16'(c <= 21));
      check($sformatf("cpb2 c%0d done", c), 16'(done2), 16'(c == 21));
      if (c == 1) start2 = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
